// File: rtl/cv32e40s_pmp_csr_if.sv
// PMP configuration bundle types and the CSR port interface
// shared by the PMP CSR block and the PMP access checker.
package cv32e40s_pmp_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_mode_e;

  typedef struct packed {
    logic       lock;
    logic [1:0] zero;
    pmp_mode_e  mode;
    logic       exec;
    logic       write;
    logic       read;
  } pmpcfg_t;

  typedef struct packed {
    logic [28:0] zero;
    logic        rlb;
    logic        mmwp;
    logic        mml;
  } mseccfg_t;

  typedef struct packed {
    pmpcfg_t [63:0]    cfg;
    logic [63:0][33:0] addr;
    mseccfg_t          mseccfg;
  } pmp_csr_t;

endpackage

interface cv32e40s_pmp_csr_if;
  logic                       csr_we_i;
  logic [1:0]                 csr_op_i;
  logic [11:0]                csr_waddr_i;
  logic [31:0]                csr_wdata_i;
  logic [11:0]                csr_raddr_i;
  logic [31:0]                csr_rdata_o;
  logic                       csr_rillegal_o;
  logic                       csr_willegal_o;
  logic                       pmp_changed_o;
  cv32e40s_pmp_pkg::pmp_csr_t csr_pmp_o;

  modport master (
    output csr_we_i, csr_op_i, csr_waddr_i,
    output csr_wdata_i, csr_raddr_i,
    input  csr_rdata_o, csr_rillegal_o,
    input  csr_willegal_o, pmp_changed_o,
    input  csr_pmp_o
  );

  modport slave (
    input  csr_we_i, csr_op_i, csr_waddr_i,
    input  csr_wdata_i, csr_raddr_i,
    output csr_rdata_o, csr_rillegal_o,
    output csr_willegal_o, pmp_changed_o,
    output csr_pmp_o
  );
endinterface

// File: rtl/cv32e40s_pmp_csr.sv
// PMP CSR state owner: pmpcfg/pmpaddr/mseccfg with Smepmp
// write-legality, combinational read port and change pulse.
module cv32e40s_pmp_csr
  import cv32e40s_pmp_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0,
  parameter int PMP_NUM_REGIONS = 0
) (
  input  logic clk,
  input  logic rst,
  cv32e40s_pmp_csr_if.slave bus
);

  localparam int G = PMP_GRANULARITY;
  localparam int N = PMP_NUM_REGIONS;
  localparam logic [31:0] NAPOT_ONES =
    (G >= 2) ? 32'(((64'd1 << G) >> 1) - 64'd1) : 32'd0;
  localparam logic [31:0] LOW_ZEROS =
    (G >= 1) ? 32'((64'd1 << G) - 64'd1) : 32'd0;

  pmpcfg_t [63:0]    cfg_q, cfg_d;
  logic [63:0][31:0] addr_q, addr_d;
  logic [63:0][31:0] addr_rd;
  logic [63:0]       locked;
  logic mml_q, mml_d, mmwp_q, mmwp_d, rlb_q, rlb_d;
  logic willegal_q, willegal_d;
  logic changed_q, changed_d;
  logic any_lock, tor_lock;

  logic r_cfg, r_addr, r_msec, r_msech;
  logic w_cfg, w_addr, w_msec, w_msech;
  logic [5:0]  ridx, widx, nidx, cidx;
  logic [31:0] wold, wnew;
  pmpcfg_t     b;

  function automatic logic [31:0] addr_view(
    logic [31:0] a, pmp_mode_e m);
    if (m == PMP_NAPOT) return a | NAPOT_ONES;
    if (m == PMP_NA4) return a;
    return a & ~LOW_ZEROS;
  endfunction

  assign r_cfg   = bus.csr_raddr_i[11:4] == 8'h3A;
  assign r_addr  = bus.csr_raddr_i >= 12'h3B0 &&
                   bus.csr_raddr_i <= 12'h3EF;
  assign r_msec  = bus.csr_raddr_i == 12'h747;
  assign r_msech = bus.csr_raddr_i == 12'h757;
  assign ridx    = 6'(bus.csr_raddr_i - 12'h3B0);

  assign w_cfg   = bus.csr_waddr_i[11:4] == 8'h3A;
  assign w_addr  = bus.csr_waddr_i >= 12'h3B0 &&
                   bus.csr_waddr_i <= 12'h3EF;
  assign w_msec  = bus.csr_waddr_i == 12'h747;
  assign w_msech = bus.csr_waddr_i == 12'h757;
  assign widx    = 6'(bus.csr_waddr_i - 12'h3B0);
  assign nidx    = widx + 6'd1;

  always_comb begin
    bus.csr_pmp_o = '0;
    for (int i = 0; i < 64; i++) begin
      addr_rd[i] = addr_view(addr_q[i], cfg_q[i].mode);
      locked[i]  = cfg_q[i].lock & ~rlb_q;
      bus.csr_pmp_o.cfg[i]  = cfg_q[i];
      bus.csr_pmp_o.addr[i] = {addr_rd[i], 2'b00};
    end
    bus.csr_pmp_o.mseccfg.mml  = mml_q;
    bus.csr_pmp_o.mseccfg.mmwp = mmwp_q;
    bus.csr_pmp_o.mseccfg.rlb  = rlb_q;
  end

  always_comb begin
    bus.csr_rdata_o    = '0;
    bus.csr_rillegal_o = 1'b0;
    unique case (1'b1)
      r_cfg:
        bus.csr_rdata_o =
          cfg_q[{bus.csr_raddr_i[3:0], 2'b00} +: 4];
      r_addr:  bus.csr_rdata_o = addr_rd[ridx];
      r_msec:
        bus.csr_rdata_o = {29'd0, rlb_q, mmwp_q, mml_q};
      r_msech: bus.csr_rdata_o = '0;
      default: bus.csr_rillegal_o = 1'b1;
    endcase
  end

  assign any_lock = |{cfg_q[63].lock, locked_all()};

  function automatic logic [62:0] locked_all();
    logic [62:0] v;
    for (int i = 0; i < 63; i++) v[i] = cfg_q[i].lock;
    return v;
  endfunction

  // A locked TOR entry also freezes the address below it.
  assign tor_lock = (int'(widx) + 1 < N) &&
                    cfg_q[nidx].lock &&
                    cfg_q[nidx].mode == PMP_TOR && !rlb_q;

  always_comb begin
    cfg_d      = cfg_q;
    addr_d     = addr_q;
    mml_d      = mml_q;
    mmwp_d     = mmwp_q;
    rlb_d      = rlb_q;
    willegal_d = 1'b0;
    b          = '0;
    cidx       = '0;
    wold       = '0;
    wnew       = '0;
    unique case (1'b1)
      w_cfg:
        wold = cfg_q[{bus.csr_waddr_i[3:0], 2'b00} +: 4];
      w_addr:  wold = addr_q[widx];
      w_msec:  wold = {29'd0, rlb_q, mmwp_q, mml_q};
      default: wold = '0;
    endcase
    unique case (bus.csr_op_i)
      2'b01:   wnew = wold | bus.csr_wdata_i;
      2'b10:   wnew = wold & ~bus.csr_wdata_i;
      default: wnew = bus.csr_wdata_i;
    endcase
    if (bus.csr_we_i) begin
      if (!(w_cfg | w_addr | w_msec | w_msech) ||
          bus.csr_op_i == 2'b11) begin
        willegal_d = 1'b1;
      end else begin
        unique case (1'b1)
          w_cfg: begin
            for (int k = 0; k < 4; k++) begin
              cidx   = {bus.csr_waddr_i[3:0], 2'(k)};
              b      = pmpcfg_t'(wnew[8*k +: 8]);
              b.zero = '0;
              if (G >= 1 && b.mode == PMP_NA4)
                b.mode = PMP_OFF;
              if (int'(cidx) < N && !locked[cidx] &&
                  !(!b.read && b.write && !mml_q) &&
                  !(mml_q && !rlb_q && b.lock &&
                    (b.exec || (!b.read && b.write))))
                cfg_d[cidx] = b;
            end
          end
          w_addr: begin
            if (int'(widx) < N && !locked[widx] && !tor_lock)
              addr_d[widx] = wnew;
          end
          w_msec: begin
            mml_d  = mml_q | wnew[0];
            mmwp_d = mmwp_q | wnew[1];
            if (rlb_q || !any_lock) rlb_d = wnew[2];
          end
          default: ;
        endcase
      end
    end
    for (int i = 0; i < 64; i++) begin
      if (i >= N) begin
        cfg_d[i]  = '0;
        addr_d[i] = '0;
      end
    end
    changed_d = (cfg_d != cfg_q) || (addr_d != addr_q) ||
                ({mml_d, mmwp_d, rlb_d} !=
                 {mml_q, mmwp_q, rlb_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      addr_q     <= '0;
      mml_q      <= 1'b0;
      mmwp_q     <= 1'b0;
      rlb_q      <= 1'b0;
      willegal_q <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      addr_q     <= addr_d;
      mml_q      <= mml_d;
      mmwp_q     <= mmwp_d;
      rlb_q      <= rlb_d;
      willegal_q <= willegal_d;
      changed_q  <= changed_d;
    end
  end

  assign bus.csr_willegal_o = willegal_q;
  assign bus.pmp_changed_o  = changed_q;

endmodule

// File: doc/cv32e40s_pmp_csr.md
Name: cv32e40s_pmp_csr

Overview:
Owns the PMP configuration state (pmpcfg, pmpaddr, mseccfg). It is the writer side of the pmp_csr_t bundle consumed by the PMP access checker.
Applies all Smepmp write-legality rules (lock, TOR lock, reserved encodings, MML/MMWP stickiness, RLB) to CSR write/set/clear requests.
Provides a combinational CSR read port and a registered change pulse so the core can flush requests that were checked under stale rules.

Parameters:
PMP_GRANULARITY, 0, G; granule is 2^(G+2) bytes.
PMP_NUM_REGIONS, 0, number of implemented entries, 0..64.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
csr_we_i  input  1  write request, single cycle, always accepted
csr_op_i  input  2  00 write, 01 set, 10 clear, 11 reserved
csr_waddr_i  input  12  CSR address of the write
csr_wdata_i  input  32  write data, or set/clear mask
csr_raddr_i  input  12  read address
csr_rdata_o  output  32  read data, combinational
csr_rillegal_o  output  1  read address not in the PMP CSR space, combinational
csr_willegal_o  output  1  registered; previous-cycle write was illegal
pmp_changed_o  output  1  registered; previous-cycle write changed at least one stored bit
csr_pmp_o  output  pmp_csr_t  cfg[i], addr[i] (34-bit = {pmpaddr[i],2'b00}), mseccfg

Behaviour:
- Reset state:
  - All cfg = 0 (mode OFF, L/R/W/X = 0), all pmpaddr = 0, mseccfg = 0.
  - csr_willegal_o = 0, pmp_changed_o = 0.
- Address map:
  - pmpcfg0..15 at 0x3A0..0x3AF; each register holds 4 entries, byte k -> entry 4N+k.
  - pmpaddr0..63 at 0x3B0..0x3EF; each holds address bits 33:2.
  - mseccfg at 0x747; mseccfgh at 0x757 reads 0 and ignores writes.
  - Entries >= PMP_NUM_REGIONS read 0 and ignore writes (legal access, no error).
- Illegal write: address outside the map, or op=11.
  - No state change.
  - csr_willegal_o=1 on the next cycle; pmp_changed_o=0.
- Write latency:
  - Request in cycle T; new value computed from current stored value: write=wdata, set=old|wdata, clear=old&~wdata.
  - Registers update at the end of T and csr_pmp_o reflects them in T+1.
  - pmp_changed_o=1 in T+1 iff any stored bit differs; both status outputs are single-cycle pulses.
  - Back-to-back writes each see the prior write's result.
- Read-during-write: csr_rdata_o returns the pre-write value in cycle T.
- Locked entry i: cfg[i].L=1 and mseccfg.rlb=0.
- pmpcfg per-byte legality (bytes evaluated independently; an illegal byte keeps its old value, other bytes update, csr_willegal_o stays 0):
  - Entry i locked -> byte ignored.
  - Bits 6:5 forced 0.
  - R=0,W=1 with mseccfg.mml=0 -> byte ignored.
  - mml=1, rlb=0, new L=1 and (X=1 or (R=0 and W=1)) -> byte ignored (no new executable M-mode or locked shared rules).
  - G>=1 and mode=NA4 -> mode stored as OFF, rest of byte accepted.
- pmpaddr[i] write ignored if:
  - entry i is locked, or
  - cfg[i+1].L=1, cfg[i+1].mode=TOR and rlb=0 (i+1 < PMP_NUM_REGIONS).
- pmpaddr read view (full value stored; granularity applied on read and on csr_pmp_o.addr):
  - G>=2 and mode=NAPOT: bits G-2:0 read 1.
  - G>=1 and mode OFF/TOR: bits G-1:0 read 0.
- mseccfg fields:
  - Bit0 mml and bit1 mmwp: set-only, cleared only by rst; clear/0-writes to them ignored.
  - Bit2 rlb:
    - Writable (set or clear) if rlb=1 or no implemented entry has L=1.
    - Otherwise writes of 1 are ignored.
  - Other bits read 0.
- Simultaneous cfg write and mml change is impossible (different CSRs, one write per cycle); the cfg checks use the mseccfg value from cycle T.
- rst asserted in the same cycle as a write: reset wins, and both status pulses are 0 the next cycle.

Test Plan:
- Reset, then read 0x3A0, 0x3B0, 0x747 -> all 0; csr_pmp_o all cfg mode OFF, addr 0.
- Write 0x3A0=0x0000_008F (entry0 L=1,NAPOT? no, L=1,TOR=01<<3? use 0x8F) -> next cycle cfg[0]=L,NA4/TOR per bits, pmp_changed_o=1. Then write 0x3B0=0x1234 -> ignored, pmp_changed_o=0. Then write 0x747=0x4 -> rlb stays 0.
- mml=0: write 0x3A0=0x0000_0F02 (entry0 R=0,W=1; entry1 NA4? byte1=0x0F) -> entry0 unchanged; entry1 updates.
- Write 0x747=0x1, then 0x747 clear op mask 0x1 -> mml remains 1. Then write entry0 cfg 0x8C (L=1,X=1) -> ignored.
- G=2 build: pmpaddr0=0xFFFF_FFF0 with NAPOT -> reads 0xFFFF_FFF1. Switched to TOR -> reads 0xFFFF_FFF0.
- Write 0x3F0 -> csr_willegal_o=1 for one cycle, no state change. Write 0x3A0 with op=11 -> same.
